// File: rtl/cpu_selftest_sequencer.sv
// Self-test controller for the multi-cycle CPU: loads a program image, runs the
// CPU until it parks on a jal-to-self loop (or times out), then checks registers.
module cpu_selftest_sequencer #(
   parameter int PROG_WORDS     = 22,
   parameter int NUM_CHECKS     = 8,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int HALT_REPEAT    = 16,
   localparam int PW = (PROG_WORDS > 1) ? $clog2(PROG_WORDS) : 1,
   localparam int CW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
   localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          start_i,
   output logic [PW-1:0] img_addr_o,
   input  logic [31:0]   img_data_i,
   output logic          mem_wr_en_o,
   output logic [31:0]   mem_wr_addr_o,
   output logic [31:0]   mem_wr_data_o,
   output logic          cpu_reset_o,
   input  logic [31:0]   pc_current_i,
   output logic [CW-1:0] exp_idx_o,
   input  logic [4:0]    exp_reg_i,
   input  logic [31:0]   exp_val_i,
   output logic [4:0]    dbg_reg_addr_o,
   input  logic [31:0]   dbg_reg_data_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          pass_o,
   output logic          timeout_o,
   output logic [CW-1:0] fail_idx_o,
   output logic [31:0]   fail_actual_o,
   output logic [TW-1:0] cycle_count_o
);

   localparam int HW = ($clog2(HALT_REPEAT + 1) > 1) ? $clog2(HALT_REPEAT + 1) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_CHECK = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [PW-1:0] LAST_WORD   = PW'(PROG_WORDS - 1);
   localparam logic [CW-1:0] LAST_CHECK  = CW'(NUM_CHECKS - 1);
   localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYCLES);
   localparam logic [HW-1:0] HALT_VAL    = HW'(HALT_REPEAT);

   logic [2:0]    state_q, state_d;
   logic [PW-1:0] word_cnt_q, word_cnt_d;
   logic [CW-1:0] chk_idx_q, chk_idx_d;
   logic [HW-1:0] halt_cnt_q, halt_cnt_d;
   logic [TW-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [31:0]   pc_prev_q, pc_prev_d;
   logic          pass_q, pass_d;
   logic          timeout_q, timeout_d;
   logic [CW-1:0] fail_idx_q, fail_idx_d;
   logic [31:0]   fail_actual_q, fail_actual_d;
   logic          mem_wr_en_q, mem_wr_en_d;
   logic          cpu_reset_q, cpu_reset_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [TW-1:0] cycle_next_s;
   logic [HW-1:0] halt_next_s;
   logic [31:0]   word_cnt_ext_s;

   // Next-state and result logic for the load/run/check sequence.
   always_comb begin
      state_d       = state_q;
      word_cnt_d    = word_cnt_q;
      chk_idx_d     = chk_idx_q;
      halt_cnt_d    = halt_cnt_q;
      cycle_cnt_d   = cycle_cnt_q;
      pc_prev_d     = pc_prev_q;
      pass_d        = pass_q;
      timeout_d     = timeout_q;
      fail_idx_d    = fail_idx_q;
      fail_actual_d = fail_actual_q;
      cycle_next_s  = cycle_cnt_q + TW'(1);
      halt_next_s   = (pc_current_i == pc_prev_q) ? (halt_cnt_q + HW'(1)) : {HW{1'b0}};

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d       = S_LOAD;
               word_cnt_d    = {PW{1'b0}};
               chk_idx_d     = {CW{1'b0}};
               pass_d        = 1'b0;
               timeout_d     = 1'b0;
               fail_idx_d    = {CW{1'b0}};
               fail_actual_d = 32'd0;
               cycle_cnt_d   = {TW{1'b0}};
            end else begin
               state_d = state_q;
            end
         end
         S_LOAD: begin
            if (word_cnt_q == LAST_WORD) begin
               state_d     = S_RUN;
               pc_prev_d   = 32'd0;
               halt_cnt_d  = {HW{1'b0}};
               cycle_cnt_d = {TW{1'b0}};
            end else begin
               word_cnt_d = word_cnt_q + PW'(1);
            end
         end
         S_RUN: begin
            pc_prev_d   = pc_current_i;
            cycle_cnt_d = cycle_next_s;
            halt_cnt_d  = halt_next_s;
            // A halt seen on the timeout cycle still counts as a halt.
            if (halt_next_s == HALT_VAL) begin
               state_d   = S_CHECK;
               chk_idx_d = {CW{1'b0}};
            end else if (cycle_next_s == TIMEOUT_VAL) begin
               state_d   = S_DONE;
               timeout_d = 1'b1;
               pass_d    = 1'b0;
            end else begin
               state_d = S_RUN;
            end
         end
         S_CHECK: begin
            if (dbg_reg_data_i != exp_val_i) begin
               state_d       = S_DONE;
               fail_idx_d    = chk_idx_q;
               fail_actual_d = dbg_reg_data_i;
               pass_d        = 1'b0;
            end else if (chk_idx_q == LAST_CHECK) begin
               state_d = S_DONE;
               pass_d  = 1'b1;
            end else begin
               chk_idx_d = chk_idx_q + CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      mem_wr_en_d = (state_d == S_LOAD);
      busy_d      = (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_CHECK);
      done_d      = (state_d == S_DONE);
      cpu_reset_d = !((state_d == S_RUN) || (state_d == S_CHECK));
   end

   // State, counters and registered status outputs.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= S_IDLE;
         word_cnt_q    <= {PW{1'b0}};
         chk_idx_q     <= {CW{1'b0}};
         halt_cnt_q    <= {HW{1'b0}};
         cycle_cnt_q   <= {TW{1'b0}};
         pc_prev_q     <= 32'd0;
         pass_q        <= 1'b0;
         timeout_q     <= 1'b0;
         fail_idx_q    <= {CW{1'b0}};
         fail_actual_q <= 32'd0;
         mem_wr_en_q   <= 1'b0;
         cpu_reset_q   <= 1'b1;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         word_cnt_q    <= word_cnt_d;
         chk_idx_q     <= chk_idx_d;
         halt_cnt_q    <= halt_cnt_d;
         cycle_cnt_q   <= cycle_cnt_d;
         pc_prev_q     <= pc_prev_d;
         pass_q        <= pass_d;
         timeout_q     <= timeout_d;
         fail_idx_q    <= fail_idx_d;
         fail_actual_q <= fail_actual_d;
         mem_wr_en_q   <= mem_wr_en_d;
         cpu_reset_q   <= cpu_reset_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign word_cnt_ext_s = 32'(word_cnt_q);
   assign img_addr_o     = word_cnt_q;
   assign mem_wr_addr_o  = {word_cnt_ext_s[29:0], 2'b00};
   assign mem_wr_data_o  = img_data_i;
   assign mem_wr_en_o    = mem_wr_en_q;
   assign cpu_reset_o    = cpu_reset_q;
   assign exp_idx_o      = chk_idx_q;
   assign dbg_reg_addr_o = exp_reg_i;
   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign pass_o         = pass_q;
   assign timeout_o      = timeout_q;
   assign fail_idx_o     = fail_idx_q;
   assign fail_actual_o  = fail_actual_q;
   assign cycle_count_o  = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_selftest_sequencer.sv
// Directed bench for cpu_selftest_sequencer using a stub CPU (PC stepper plus register file).
module tb_cpu_selftest_sequencer;

   localparam int NW = 22;
   localparam logic [31:0] HALT_PC = 32'h54;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_i;
   logic        start_i;
   logic [4:0]  img_addr;
   logic [31:0] img_data;
   logic        mem_wr_en;
   logic [31:0] mem_wr_addr, mem_wr_data;
   logic        cpu_reset;
   logic [31:0] pc_q;
   logic [2:0]  exp_idx;
   logic [4:0]  exp_reg;
   logic [31:0] exp_val;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;
   logic        busy, done, pass, timeout;
   logic [2:0]  fail_idx;
   logic [31:0] fail_actual;
   logic [7:0]  cycle_count;

   logic [31:0] rom [NW];
   logic [31:0] rf [32];
   logic [4:0]  exp_reg_tab [5];
   logic [31:0] exp_val_tab [5];
   logic        pingpong;
   logic [1:0]  div_q;

   int          n_assert = 0;
   int          n_fail = 0;
   int          wr_count = 0;
   logic [31:0] wr_addr_log [64];
   logic [31:0] wr_data_log [64];

   assign img_data = (img_addr < 5'd22) ? rom[img_addr] : 32'd0;
   assign exp_reg  = (exp_idx < 3'd5) ? exp_reg_tab[exp_idx] : 5'd0;
   assign exp_val  = (exp_idx < 3'd5) ? exp_val_tab[exp_idx] : 32'd0;
   assign dbg_data = rf[dbg_addr];

   cpu_selftest_sequencer #(
      .PROG_WORDS(22), .NUM_CHECKS(5), .TIMEOUT_CYCLES(200), .HALT_REPEAT(16)
   ) dut (
      .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
      .img_addr_o(img_addr), .img_data_i(img_data),
      .mem_wr_en_o(mem_wr_en), .mem_wr_addr_o(mem_wr_addr), .mem_wr_data_o(mem_wr_data),
      .cpu_reset_o(cpu_reset), .pc_current_i(pc_q),
      .exp_idx_o(exp_idx), .exp_reg_i(exp_reg), .exp_val_i(exp_val),
      .dbg_reg_addr_o(dbg_addr), .dbg_reg_data_i(dbg_data),
      .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(timeout),
      .fail_idx_o(fail_idx), .fail_actual_o(fail_actual), .cycle_count_o(cycle_count)
   );

   // Single-check instance: program of 2 words, CPU parked at PC 0, checks x0 == 0.
   logic        s_start;
   logic [0:0]  s_img_addr, s_exp_idx, s_fail_idx;
   logic [31:0] s_img_data, s_wr_addr, s_wr_data, s_fail_actual, s_dbg_data;
   logic        s_wr_en, s_cpu_reset, s_busy, s_done, s_pass, s_timeout;
   logic [4:0]  s_dbg_addr;
   logic [7:0]  s_cycle_count;
   logic [31:0] s_pc = 32'd0;
   logic [4:0]  s_exp_reg = 5'd0;
   logic [31:0] s_exp_val = 32'd0;

   assign s_img_data = rom[s_img_addr];
   assign s_dbg_data = rf[s_dbg_addr];

   cpu_selftest_sequencer #(
      .PROG_WORDS(2), .NUM_CHECKS(1), .TIMEOUT_CYCLES(200), .HALT_REPEAT(16)
   ) dut1 (
      .clk_i(clk), .reset_i(reset_i), .start_i(s_start),
      .img_addr_o(s_img_addr), .img_data_i(s_img_data),
      .mem_wr_en_o(s_wr_en), .mem_wr_addr_o(s_wr_addr), .mem_wr_data_o(s_wr_data),
      .cpu_reset_o(s_cpu_reset), .pc_current_i(s_pc),
      .exp_idx_o(s_exp_idx), .exp_reg_i(s_exp_reg), .exp_val_i(s_exp_val),
      .dbg_reg_addr_o(s_dbg_addr), .dbg_reg_data_i(s_dbg_data),
      .busy_o(s_busy), .done_o(s_done), .pass_o(s_pass), .timeout_o(s_timeout),
      .fail_idx_o(s_fail_idx), .fail_actual_o(s_fail_actual), .cycle_count_o(s_cycle_count)
   );

   // Stub CPU: advances PC by 4 every third cycle until the halt loop, or ping-pongs 0/4.
   always @(posedge clk) begin
      if (cpu_reset) begin
         pc_q  <= 32'd0;
         div_q <= 2'd0;
      end else if (div_q == 2'd2) begin
         div_q <= 2'd0;
         if (pingpong) pc_q <= pc_q ^ 32'h4;
         else if (pc_q != HALT_PC) pc_q <= pc_q + 32'd4;
      end else begin
         div_q <= div_q + 2'd1;
      end
   end

   // Log every memory write for later comparison with the image.
   always @(posedge clk) begin
      if (mem_wr_en === 1'b1) begin
         wr_addr_log[wr_count % 64] <= mem_wr_addr;
         wr_data_log[wr_count % 64] <= mem_wr_data;
         wr_count <= wr_count + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int busy_n);
      int n = 0;
      busy_n = 0;
      while (done !== 1'b1 && n < budget) begin
         if (busy === 1'b1) busy_n++;
         n++;
         @(negedge clk);
      end
      chk("done_reached", {31'd0, done}, 32'd1);
   endtask

   task automatic check_writes(input int base);
      chk("write_count", wr_count - base, NW);
      for (int i = 0; i < NW; i++) begin
         chk("write_addr", wr_addr_log[(base + i) % 64], 32'(i * 4));
         chk("write_data", wr_data_log[(base + i) % 64], rom[i]);
      end
   endtask

   initial begin
      int base;
      int busy_n;
      int n;
      for (int i = 0; i < NW - 1; i++) rom[i] = 32'h0010_0093 + 32'(i * 32'h111);
      rom[NW - 1] = 32'h0000_006F;
      for (int i = 0; i < 32; i++) rf[i] = 32'hDEAD_0000 + 32'(i);
      rf[0] = 32'd0; rf[1] = 32'd5; rf[2] = 32'd10; rf[3] = 32'd5; rf[4] = 32'd3; rf[5] = 32'h4C;
      exp_reg_tab[0] = 5'd1; exp_reg_tab[1] = 5'd2; exp_reg_tab[2] = 5'd3;
      exp_reg_tab[3] = 5'd4; exp_reg_tab[4] = 5'd5;
      exp_val_tab[0] = 32'd5; exp_val_tab[1] = 32'd10; exp_val_tab[2] = 32'd5;
      exp_val_tab[3] = 32'd3; exp_val_tab[4] = 32'h4C;
      pingpong = 1'b0;
      start_i  = 1'b0;
      s_start  = 1'b0;
      reset_i  = 1'b1;
      repeat (3) @(negedge clk);
      reset_i = 1'b0;
      @(negedge clk);

      // Reset state
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_pass", {31'd0, pass}, 32'd0);
      chk("rst_timeout", {31'd0, timeout}, 32'd0);
      chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      chk("rst_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
      chk("rst_fail_idx", {29'd0, fail_idx}, 32'd0);
      chk("rst_fail_actual", fail_actual, 32'd0);
      chk("rst_cycle_count", {24'd0, cycle_count}, 32'd0);

      // Test 1: branch program, all checks match
      base = wr_count;
      pulse_start();
      chk("t1_load_busy", {31'd0, busy}, 32'd1);
      chk("t1_load_wr_en", {31'd0, mem_wr_en}, 32'd1);
      chk("t1_load_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      chk("t1_load_img_addr", {27'd0, img_addr}, 32'd0);
      wait_done(400, busy_n);
      chk("t1_busy_cycles", busy_n, 32'd107);
      chk("t1_pass", {31'd0, pass}, 32'd1);
      chk("t1_timeout", {31'd0, timeout}, 32'd0);
      chk("t1_cycle_count", {24'd0, cycle_count}, 32'd80);
      chk("t1_done_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      chk("t1_done_wr_en", {31'd0, mem_wr_en}, 32'd0);
      chk("t1_done_busy", {31'd0, busy}, 32'd0);
      check_writes(base);

      // Test 2: entry 3 expects x4=4; restart from DONE clears results
      exp_val_tab[3] = 32'd4;
      pulse_start();
      chk("t2_restart_pass", {31'd0, pass}, 32'd0);
      chk("t2_restart_done", {31'd0, done}, 32'd0);
      chk("t2_restart_cycles", {24'd0, cycle_count}, 32'd0);
      wait_done(400, busy_n);
      chk("t2_busy_cycles", busy_n, 32'd106);
      chk("t2_pass", {31'd0, pass}, 32'd0);
      chk("t2_timeout", {31'd0, timeout}, 32'd0);
      chk("t2_fail_idx", {29'd0, fail_idx}, 32'd3);
      chk("t2_fail_actual", fail_actual, 32'd3);

      // Test 5: start during LOAD is ignored; fail fields cleared on restart
      exp_val_tab[3] = 32'd3;
      base = wr_count;
      pulse_start();
      chk("t5_clear_fail_idx", {29'd0, fail_idx}, 32'd0);
      chk("t5_clear_fail_actual", fail_actual, 32'd0);
      repeat (4) @(negedge clk);
      pulse_start();
      wait_done(400, busy_n);
      chk("t5_pass", {31'd0, pass}, 32'd1);
      check_writes(base);

      // Test 3: ping-pong loop never halts, timeout after 200 RUN cycles
      pingpong = 1'b1;
      pulse_start();
      wait_done(600, busy_n);
      chk("t3_busy_cycles", busy_n, 32'd222);
      chk("t3_timeout", {31'd0, timeout}, 32'd1);
      chk("t3_cycle_count", {24'd0, cycle_count}, 32'd200);
      chk("t3_pass", {31'd0, pass}, 32'd0);
      chk("t3_fail_idx", {29'd0, fail_idx}, 32'd0);

      // Test 4: reset mid-RUN
      pulse_start();
      n = 0;
      while (cpu_reset !== 1'b0 && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("t4_run_entered", {31'd0, cpu_reset}, 32'd0);
      repeat (10) @(negedge clk);
      chk("t4_mid_run_cycles", {24'd0, cycle_count}, 32'd10);
      reset_i = 1'b1;
      @(negedge clk);
      reset_i = 1'b0;
      chk("t4_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      chk("t4_busy", {31'd0, busy}, 32'd0);
      chk("t4_done", {31'd0, done}, 32'd0);
      chk("t4_timeout", {31'd0, timeout}, 32'd0);
      chk("t4_cycle_count", {24'd0, cycle_count}, 32'd0);
      chk("t4_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
      @(negedge clk);
      chk("t4_still_idle", {31'd0, busy}, 32'd0);

      // Test 6: single-check instance
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      n = 0;
      busy_n = 0;
      while (s_done !== 1'b1 && n < 100) begin
         if (s_busy === 1'b1) busy_n++;
         n++;
         @(negedge clk);
      end
      chk("t6_done", {31'd0, s_done}, 32'd1);
      chk("t6_busy_cycles", busy_n, 32'd19);
      chk("t6_pass", {31'd0, s_pass}, 32'd1);
      chk("t6_cycle_count", {24'd0, s_cycle_count}, 32'd16);
      chk("t6_timeout", {31'd0, s_timeout}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
